// File: rtl/mem_block_arbiter.sv
// Shares one 256-bit block memory port between the I-fetch read path and the D-cache read/write path.
// Define ARB_TIMEOUT_EN to add a watchdog that abandons a stalled access and raises sticky err.
module mem_block_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT_CYC  = 255
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         i_req,
   input  logic [31:0]  i_addr,
   output logic [255:0] i_rdata,
   output logic         i_done,
   input  logic         d_req,
   input  logic         d_we,
   input  logic [31:0]  d_addr,
   input  logic [255:0] d_wdata,
   output logic [255:0] d_rdata,
   output logic         d_done,
   output logic [31:0]  mem_addr,
   output logic         mem_blk_read,
   output logic         mem_blk_write,
   output logic [255:0] mem_wdata,
   input  logic [255:0] mem_rdata,
   input  logic         mem_read_valid,
   input  logic         mem_write_valid,
   output logic         busy,
   output logic         err
);
   localparam int SCW = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

   typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, RESP} state_t;

   state_t         state_q, state_d;
   logic           owner_is_d_q, owner_is_d_d;
   logic [SCW-1:0] starve_q, starve_d;
   logic [31:0]    addr_q, addr_d;
   logic [255:0]   wdata_q, wdata_d;
   logic [255:0]   irdata_q, irdata_d;
   logic [255:0]   drdata_q, drdata_d;
   logic           rd_q, wr_q, idone_q, ddone_q, busy_q;
   logic           in_wait, vld_hit, force_i, tmo;

   assign in_wait = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);
   // Only the valid matching the strobe we are holding counts; the other one is ignored.
   assign vld_hit = (state_q == D_WR) ? mem_write_valid : (in_wait && mem_read_valid);
   assign force_i = i_req && (starve_q == STARVE_MAX);

   always_comb begin
      state_d      = state_q;
      owner_is_d_d = owner_is_d_q;
      starve_d     = starve_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      irdata_d     = irdata_q;
      drdata_d     = drdata_q;
      case (state_q)
         IDLE: begin
            if (d_req && !force_i) begin
               owner_is_d_d = 1'b1;
               addr_d       = d_addr;
               // A D grant with I waiting cannot occur at STARVE_MAX, so this never wraps.
               starve_d     = i_req ? starve_q + SCW'(1) : '0;
               if (d_we) begin
                  wdata_d = d_wdata;
                  state_d = D_WR;
               end else begin
                  state_d = D_RD;
               end
            end else if (i_req) begin
               owner_is_d_d = 1'b0;
               addr_d       = i_addr;
               starve_d     = '0;
               state_d      = I_RD;
            end
         end
         I_RD, D_RD, D_WR: begin
            if (vld_hit) begin
               state_d = RESP;
               if (state_q == I_RD) irdata_d = mem_rdata;
               if (state_q == D_RD) drdata_d = mem_rdata;
            end else if (tmo) begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= IDLE;
         owner_is_d_q <= 1'b0;
         starve_q     <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         irdata_q     <= '0;
         drdata_q     <= '0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         idone_q      <= 1'b0;
         ddone_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_is_d_q <= owner_is_d_d;
         starve_q     <= starve_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         irdata_q     <= irdata_d;
         drdata_q     <= drdata_d;
         rd_q         <= (state_d == I_RD) || (state_d == D_RD);
         wr_q         <= (state_d == D_WR);
         idone_q      <= (state_d == RESP) && !owner_is_d_d;
         ddone_q      <= (state_d == RESP) && owner_is_d_d;
         busy_q       <= (state_d != IDLE);
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int TCW = $clog2(TIMEOUT_CYC + 1);
   logic [TCW-1:0] wdog_q;
   logic           err_q;

   // wdog_q counts completed wait cycles, so the strobe stays up exactly TIMEOUT_CYC cycles.
   assign tmo = in_wait && (wdog_q == TCW'(TIMEOUT_CYC - 1));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state_d != state_q) wdog_q <= '0;
         else if (in_wait)       wdog_q <= wdog_q + 1'b1;
         if (tmo && !vld_hit)    err_q  <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

   assign i_rdata       = irdata_q;
   assign d_rdata       = drdata_q;
   assign i_done        = idone_q;
   assign d_done        = ddone_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign mem_blk_read  = rd_q;
   assign mem_blk_write = wr_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_mem_block_arbiter.sv
// Bench for mem_block_arbiter: directed scenarios then randomized traffic, every cycle compared
// against a transaction-level reference model with its own backing memory.
module tb_mem_block_arbiter;
   localparam int STARVE_LIMIT = 4;
   localparam int TIMEOUT_CYC  = 8;
   localparam logic [255:0] PAT_A = {8{32'hA5A5_1234}};
   localparam logic [255:0] PAT_B = {8{32'h0BAD_F00D}};

   logic         CLK = 1'b0;
   logic         RESET;
   logic         i_req, d_req, d_we;
   logic [31:0]  i_addr, d_addr, mem_addr;
   logic [255:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
   logic         i_done, d_done, mem_blk_read, mem_blk_write;
   logic         mem_read_valid, mem_write_valid, busy, err;

   mem_block_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .CLK(CLK), .RESET(RESET),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_addr(mem_addr), .mem_blk_read(mem_blk_read), .mem_blk_write(mem_blk_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_read_valid(mem_read_valid), .mem_write_valid(mem_write_valid),
      .busy(busy), .err(err)
   );

   always #5 CLK = ~CLK;

   int vectors, miscompares;

   // Reference model: transaction phase (0 free, 1 memory access, 2 completion), owner 1=I 2=D.
   int           m_phase, m_owner, m_starve, m_wait;
   bit           m_we, m_err;
   logic [31:0]  m_addr;
   logic [255:0] m_wd, m_irdata, m_drdata;
   logic [255:0] mem_m [logic [31:0]];
   bit           e_rd, e_wr, e_idone, e_ddone, e_busy;

   int    lat_cnt, lat_tgt, lat_min, lat_max;
   int    p_i, p_d, p_spur, n_rd_cyc;
   string done_log;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'($urandom_range(7)) << 5;
   endfunction

   function automatic logic [255:0] mem_rd(input logic [31:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return {8{a}};
   endfunction

   task automatic set_lat(input int lo, input int hi);
      lat_min = lo;
      lat_max = hi;
      lat_tgt = $urandom_range(hi, lo);
      lat_cnt = 0;
   endtask

   task automatic model_reset();
      m_phase = 0; m_owner = 0; m_starve = 0; m_wait = 0; m_we = 0; m_err = 0;
      m_addr = '0; m_wd = '0; m_irdata = '0; m_drdata = '0;
      e_rd = 0; e_wr = 0; e_idone = 0; e_ddone = 0; e_busy = 0;
      lat_cnt = 0;
   endtask

   // One clock: requesters and memory react, model predicts the edge, then outputs are compared.
   task automatic cycle();
      if (e_idone) i_req = 1'b0;
      else if (!i_req && $urandom_range(99) < p_i) begin
         i_req = 1'b1; i_addr = rand_addr();
      end
      if (e_ddone) d_req = 1'b0;
      else if (!d_req && $urandom_range(99) < p_d) begin
         d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = rand_addr(); d_wdata = rand256();
      end

      mem_read_valid = 1'b0; mem_write_valid = 1'b0; mem_rdata = rand256();
      if (m_phase == 1) begin
         if (lat_cnt >= lat_tgt) begin
            if (m_we) mem_write_valid = 1'b1;
            else begin
               mem_read_valid = 1'b1; mem_rdata = mem_rd(m_addr);
            end
            lat_cnt = 0; lat_tgt = $urandom_range(lat_max, lat_min);
         end else lat_cnt++;
      end
      if (!mem_read_valid && !mem_write_valid && $urandom_range(99) < p_spur) begin
         if (m_phase == 1) begin
            if (m_we) mem_read_valid = 1'b1; else mem_write_valid = 1'b1;
         end else if ($urandom_range(1) == 1) mem_read_valid = 1'b1;
         else mem_write_valid = 1'b1;
      end

      case (m_phase)
         0: begin
            if (d_req && !(i_req && m_starve == STARVE_LIMIT)) begin
               m_owner = 2; m_we = d_we; m_addr = d_addr;
               if (d_we) m_wd = d_wdata;
               m_starve = !i_req ? 0 : (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
               m_phase = 1; m_wait = 0; lat_cnt = 0;
            end else if (i_req) begin
               m_owner = 1; m_we = 0; m_addr = i_addr; m_starve = 0;
               m_phase = 1; m_wait = 0; lat_cnt = 0;
            end
         end
         1: begin
            if (m_we ? mem_write_valid : mem_read_valid) begin
               if (m_we) mem_m[m_addr] = m_wd;
               else if (m_owner == 1) m_irdata = mem_rdata;
               else m_drdata = mem_rdata;
               m_phase = 2;
            end else begin
               m_wait++;
`ifdef ARB_TIMEOUT_EN
               if (m_wait == TIMEOUT_CYC) begin
                  m_phase = 2; m_err = 1;
               end
`endif
            end
         end
         default: m_phase = 0;
      endcase
      e_rd    = (m_phase == 1) && !m_we;
      e_wr    = (m_phase == 1) && m_we;
      e_idone = (m_phase == 2) && (m_owner == 1);
      e_ddone = (m_phase == 2) && (m_owner == 2);
      e_busy  = (m_phase != 0);

      @(posedge CLK);
      #1;
      chk("mem_blk_read", mem_blk_read, e_rd);
      chk("mem_blk_write", mem_blk_write, e_wr);
      chk("strobe_onehot", mem_blk_read & mem_blk_write, 1'b0);
      chk("i_done", i_done, e_idone);
      chk("d_done", d_done, e_ddone);
      chk("busy", busy, e_busy);
      chk("err", err, m_err);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wd);
      chk("i_rdata", i_rdata, m_irdata);
      chk("d_rdata", d_rdata, m_drdata);
      if (i_done) done_log = {done_log, "I"};
      if (d_done) done_log = {done_log, "D"};
      if (mem_blk_read) n_rd_cyc++;
   endtask

   task automatic drain();
      p_i = 0; p_d = 0; p_spur = 0;
      for (int k = 0; k < 200 && (m_phase != 0 || i_req || d_req); k++) cycle();
      chk("drain_idle", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      vectors = 0; miscompares = 0;
      RESET = 1'b0;
      i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      mem_rdata = '0; mem_read_valid = 0; mem_write_valid = 0;
      p_i = 0; p_d = 0; p_spur = 0; n_rd_cyc = 0; done_log = "";
      set_lat(0, 0);
      model_reset();
      mem_m[32'h0040_0000] = PAT_A;

      repeat (2) cycle();
      RESET = 1'b1;

      // Reset in the middle of a D read whose valid never comes.
      set_lat(1000, 1000);
      d_req = 1; d_we = 0; d_addr = 32'h0000_1000;
      cycle();
      chk("rst_mid_strobe_up", mem_blk_read, 1'b1);
      cycle();
      cycle();
      #2 RESET = 1'b0;
      #1;
      chk("rst_mid_strobe_drop", mem_blk_read, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_addr", mem_addr, 32'h0);
      chk("rst_mid_ddone", d_done, 1'b0);
      model_reset();
      d_req = 0; done_log = "";
      cycle();
      cycle();
      RESET = 1'b1;
      cycle();
      cycle();
      chk("rst_mid_no_done", done_log.len(), 0);

      // Single I read at minimum latency.
      set_lat(0, 0); done_log = "";
      i_req = 1; i_addr = 32'h0040_0000;
      cycle();
      chk("i_rd_strobe_c1", mem_blk_read, 1'b1);
      chk("i_rd_addr_c1", mem_addr, 32'h0040_0000);
      chk("i_rd_nodone_c1", i_done, 1'b0);
      cycle();
      chk("i_rd_done_c2", i_done, 1'b1);
      chk("i_rd_data_c2", i_rdata, PAT_A);
      chk("i_rd_strobe_c2", mem_blk_read, 1'b0);
      cycle();
      chk("i_rd_idle_c3", busy, 1'b0);
      chk("i_rd_done_c3", i_done, 1'b0);
      chk("i_rd_log", done_log == "I", 1'b1);

      // Collision: D write wins, then I read.
      done_log = "";
      i_req = 1; i_addr = 32'h0000_3000;
      d_req = 1; d_we = 1; d_addr = 32'h0000_2000; d_wdata = PAT_B;
      cycle();
      chk("col_wr_first", mem_blk_write, 1'b1);
      chk("col_wdata", mem_wdata, PAT_B);
      chk("col_addr", mem_addr, 32'h0000_2000);
      for (int k = 0; k < 20 && done_log.len() < 2; k++) cycle();
      chk("col_order", done_log == "DI", 1'b1);
      drain();

      // Starvation: both sides keep requesting.
      done_log = ""; p_i = 100; p_d = 100;
      i_req = 1; i_addr = 32'h0000_4000;
      d_req = 1; d_we = 0; d_addr = 32'h0000_5000;
      for (int k = 0; k < 100 && done_log.len() < 10; k++) cycle();
      chk("starve_order", done_log == "DDDDIDDDDI", 1'b1);
      drain();

      // Long memory latency.
      done_log = ""; n_rd_cyc = 0; set_lat(19, 19);
      d_req = 1; d_we = 0; d_addr = 32'h0000_1000;
      for (int k = 0; k < 40 && done_log.len() < 1; k++) cycle();
      chk("long_strobe_cycles", n_rd_cyc, 20);
      chk("long_single_done", done_log == "D", 1'b1);
      cycle();
      cycle();
      chk("long_no_extra_done", done_log == "D", 1'b1);

`ifdef ARB_TIMEOUT_EN
      // Watchdog: valid never arrives.
      done_log = ""; n_rd_cyc = 0; set_lat(1000, 1000);
      i_req = 1; i_addr = 32'h0040_0000;
      for (int k = 0; k < 40 && done_log.len() < 1; k++) cycle();
      chk("tmo_strobe_cycles", n_rd_cyc, TIMEOUT_CYC);
      chk("tmo_err", err, 1'b1);
      chk("tmo_done", done_log == "I", 1'b1);
      repeat (5) cycle();
      chk("tmo_err_sticky", err, 1'b1);
      RESET = 1'b0;
      #1;
      chk("tmo_err_reset", err, 1'b0);
      model_reset();
      cycle();
      RESET = 1'b1;
`endif

      // Randomized traffic with spurious valids.
      set_lat(0, 5);
      p_i = 30; p_d = 30; p_spur = 15;
      repeat (600) cycle();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mem_block_arbiter.md
# mem_block_arbiter

Shares one block-wide (256-bit) memory port between the instruction-fetch block-read path (iBlkRead) and the data-cache block read/write path (dBlkRead/dBlkWrite) of the pipelined MIPS core. It sits between the core's cache-side block requests and the simulator memory's block interface. It serialises transactions through a small FSM with data-side priority and an instruction-side anti-starvation counter. One transaction is in flight at a time; each requester gets a one-cycle completion pulse.

## Interface
- STARVE_LIMIT, 4: consecutive D grants allowed while i_req is pending before I is forced.
- TIMEOUT_CYC, 255: watchdog limit in cycles; used only with ARB_TIMEOUT_EN.
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction block-read request; level, held until i_done.
- i_addr  in  32  block address for the I read.
- i_rdata  out  256  registered block returned to the I side.
- i_done  out  1  one-cycle completion pulse for I.
- d_req  in  1  data block request; level, held until d_done.
- d_we  in  1  1 = block write (writeback), 0 = block read.
- d_addr  in  32  block address for D.
- d_wdata  in  256  writeback data.
- d_rdata  out  256  registered block returned to the D side.
- d_done  out  1  one-cycle completion pulse for D.
- mem_addr  out  32  address to memory.
- mem_blk_read  out  1  block read strobe.
- mem_blk_write  out  1  block write strobe.
- mem_wdata  out  256  block write data.
- mem_rdata  in  256  block read data.
- mem_read_valid  in  1  block read complete; mem_rdata valid this cycle.
- mem_write_valid  in  1  block write complete.
- busy  out  1  FSM not in IDLE.
- err  out  1  sticky timeout flag; constant 0 without ARB_TIMEOUT_EN.

## Operation
- States: IDLE, I_RD, D_RD, D_WR, RESP.
- IDLE: sample requests. Grant goes to D if d_req is high, unless i_req is high and starve_cnt == STARVE_LIMIT. In that case, or when only i_req is high, grant goes to I.
- On grant:
  - Latch address into mem_addr. For D_WR, also latch d_wdata into mem_wdata.
  - Record the owner.
  - Go to I_RD, D_RD (d_we=0) or D_WR (d_we=1).
- I_RD/D_RD: hold mem_blk_read=1. On mem_read_valid, capture mem_rdata into the owner's rdata register, drop the strobe, and go to RESP.
- D_WR: hold mem_blk_write=1. On mem_write_valid, drop the strobe and go to RESP.
- RESP: pulse the owner's done for exactly one cycle, then go to IDLE. Requests are ignored in RESP.
- Requester contract: deassert req at the clock edge that samples done=1, so the next IDLE cycle sees the updated req.
- starve_cnt (3+ bits, saturating at STARVE_LIMIT):
  - Increments on a D grant while i_req=1.
  - Clears on any I grant, or on a D grant while i_req=0.
- Valid inputs arriving outside the matching state are ignored.
- Only one strobe is ever high.
- mem_addr and mem_wdata hold their last values in IDLE/RESP.
- rdata registers hold until the next capture for that owner.

## Timing
- Reset (RESET=0, asynchronous):
  - State goes to IDLE and starve_cnt to 0.
  - All outputs go to 0, including i_rdata, d_rdata, mem_addr, mem_wdata, busy and err.
  - Strobes drop immediately. An in-flight transaction is abandoned and gets no done pulse.
- Minimum latency, with req high in IDLE at cycle 0:
  - Strobe high in cycle 1.
  - If valid arrives in cycle 1, done=1 and rdata is valid in cycle 2.
  - IDLE again in cycle 3.
  - Back-to-back transactions repeat every 3 cycles minimum.
- Strobes are registered outputs and stay high every cycle until the matching valid is sampled.
- Simultaneous i_req and d_req: D wins unless starve_cnt == STARVE_LIMIT.
- busy = (state != IDLE), registered.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A watchdog counts cycles in I_RD/D_RD/D_WR.
  - If the count reaches TIMEOUT_CYC without valid: drop the strobe, set err=1 (sticky until reset), and go to RESP. The owner gets done with rdata unchanged.
  - The counter clears on every state entry.
- ARB_TIMEOUT_EN undefined: no counter, the FSM waits indefinitely, and err is tied to 0.

## Test plan
- Reset mid-transaction: d_req, d_we=0, address 0x1000 with valid withheld; pull RESET low in D_RD -> mem_blk_read=0 immediately, no d_done, busy=0, outputs 0.
- Single I read: i_req, i_addr=0x0040_0000, valid one cycle after the strobe with mem_rdata=pattern A -> mem_addr=0x0040_0000, i_done pulses once at cycle 2, i_rdata=A, d_done never fires.
- Collision: i_req and d_req both high in IDLE with d_we=1, d_addr=0x2000, d_wdata=B -> D_WR first with mem_wdata=B, then I_RD. Expect d_done before i_done and exactly one strobe high at any time.
- Starvation: i_req held with d_req re-asserted after every d_done, STARVE_LIMIT=4 -> 4 D grants, then an I grant, and starve_cnt returns to 0.
- Long memory latency: valid after 20 cycles -> strobe stays high 20 cycles, single done pulse, mem_addr stable throughout.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYC=8): valid never arrives -> strobe drops after 8 cycles, err=1, done pulses, err stays 1 until RESET.
